uart_tx_fifo: RTL

Parametrised UART transmitter with a built-in TX FIFO. Supports configurable data width, optional odd/even parity and 1 or 2 stop bits. Upstream logic pushes words over a valid/ready handshake, and the block serialises them LSB-first, back-to-back with no idle gap while data is queued. It is the drop-in successor to the single-word transmitter for bursty producers such as a command/response engine or debug console.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 33 +++
 rtl/uart_tx_fifo.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the transmitter and the future receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // Returns 0 for unusable settings so the caller's range check fires.
  function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                               input int unsigned baud);
    if (baud == 0 || clk_freq < baud) return 0;
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter; baud_tick marks the last clock of each bit period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic baud_tick
);

  localparam int unsigned Divisor = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CntW    = (Divisor > 2) ? $clog2(Divisor) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Divisor - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign baud_tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntOne;
    if (restart || baud_tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO; frames are sent LSB-first and back-to-back while queued.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done
);

  localparam int unsigned Divisor   = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam bit          HasParity = (PARITY != 32'(PAR_NONE));
  localparam bit          OddParity = (PARITY == 32'(PAR_ODD));
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [3:0]      LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0]      LastStop = 4'(STOP_BITS - 1);

  if (Divisor < 2) begin : g_chk_div
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (PARITY > 2) begin : g_chk_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  // FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]        count_q, count_d;
  logic                 push, pop, fifo_empty;
  logic [DATA_BITS-1:0] head;

  tx_state_e            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 load, restart, baud_tick;

  assign tx_ready   = (count_q != CntFull);
  assign push       = tx_valid && tx_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign tx_serial  = tx_q;
  assign tx_busy    = (state_q != StIdle) || !fifo_empty;

  uart_baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .baud_tick (baud_tick)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_d     = par_q;
    tx_d      = tx_q;
    load      = 1'b0;
    tx_done   = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        load = !fifo_empty;
      end
      StStart: begin
        if (baud_tick) begin
          state_d   = StData;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
        end
      end
      StData: begin
        if (baud_tick) begin
          if (bit_cnt_q == LastData) begin
            bit_cnt_d = '0;
            state_d   = HasParity ? StParity : StStop;
            tx_d      = HasParity ? par_q : 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (baud_tick) begin
          state_d   = StStop;
          tx_d      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (bit_cnt_q == LastStop) begin
            tx_done = 1'b1;
            load    = !fifo_empty;
            state_d = StIdle;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // A pop starts the next frame directly, whether from idle or the last stop cycle.
    if (load) begin
      state_d = StStart;
      shift_d = head;
      par_d   = (^head) ^ OddParity;
      tx_d    = 1'b0;
    end
  end

  assign pop     = load;
  assign restart = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
    end
  end

endmodule
